// File: rtl/data_mem_responder.sv
// ============================================================================
// Module   : data_mem_responder
// Purpose  : Memory-side slave for the ReadEnable/WriteEnable/DataMem_Ready
//            handshake; word RAM with byte-lane writes and programmable waits.
//            Optional macro DMEM_RAND_WAIT_EN adds 0..3 LFSR-driven wait cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] MWriteData,
  input  logic [3:0]  WriteEnable,
  input  logic        ReadEnable,
  output logic [31:0] MReadData,
  output logic        DataMem_Ready,
  output logic        Busy
);

  localparam int         c_depth      = 2 ** ADDR_WIDTH;
  localparam logic [4:0] c_lat        = 5'(LATENCY);
  localparam logic [1:0] c_state_idle = 2'd0;
  localparam logic [1:0] c_state_wait = 2'd1;
  localparam logic [1:0] c_state_resp = 2'd2;

  logic [1:0]            r_state;
  logic [4:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [3:0]            r_we;
  logic [31:0]           r_wdata;
  logic                  r_rd;
  logic [31:0]           r_rdata;
  logic [31:0]           r_mem [c_depth];

  logic                  w_req;
  logic                  w_accept;
  logic [4:0]            w_extra;
  logic [4:0]            w_total;
  logic                  w_enter_resp;
  logic                  w_commit;
  logic [ADDR_WIDTH-1:0] w_c_idx;
  logic [3:0]            w_c_we;
  logic [31:0]           w_c_wdata;
  logic                  w_c_rd;
  logic                  w_unused;

  assign w_req    = ReadEnable | (|WriteEnable);
  assign w_accept = (r_state == c_state_idle) & w_req;
  assign w_total  = c_lat + w_extra;
  assign w_unused = ^{Address[31:ADDR_WIDTH+2], Address[1:0]};

`ifdef DMEM_RAND_WAIT_EN
  logic [7:0] r_lfsr;

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1, stepped once per accepted request
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_lfsr <= 8'hA5;
    end else if (w_accept) begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
  end

  assign w_extra = {3'b000, r_lfsr[1:0]};
`else
  assign w_extra = 5'd0;
`endif

  // A zero-wait access commits straight from IDLE, so use the live inputs there
  assign w_c_idx   = (r_state == c_state_idle) ? Address[ADDR_WIDTH+1:2] : r_idx;
  assign w_c_we    = (r_state == c_state_idle) ? WriteEnable : r_we;
  assign w_c_wdata = (r_state == c_state_idle) ? MWriteData : r_wdata;
  assign w_c_rd    = (r_state == c_state_idle) ? ReadEnable : r_rd;

  assign w_enter_resp = (w_accept & (w_total == 5'd0)) |
                        ((r_state == c_state_wait) & (r_cnt == 5'd1));
  assign w_commit     = w_enter_resp & ~reset;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= c_state_idle;
      r_cnt   <= 5'd0;
      r_idx   <= '0;
      r_we    <= 4'd0;
      r_wdata <= 32'h0;
      r_rd    <= 1'b0;
      r_rdata <= 32'h0;
    end else begin
      case (r_state)
        c_state_idle: begin
          if (w_accept) begin
            r_idx   <= Address[ADDR_WIDTH+1:2];
            r_we    <= WriteEnable;
            r_wdata <= MWriteData;
            r_rd    <= ReadEnable;
            r_cnt   <= w_total;
            r_state <= (w_total == 5'd0) ? c_state_resp : c_state_wait;
          end
        end
        c_state_wait: begin
          r_cnt <= r_cnt - 5'd1;
          if (r_cnt == 5'd1) begin
            r_state <= c_state_resp;
          end
        end
        c_state_resp: r_state <= c_state_idle;
        default:      r_state <= c_state_idle;
      endcase
      // Read-before-write: the old word is captured on the same commit edge
      if (w_commit && w_c_rd) begin
        r_rdata <= r_mem[w_c_idx];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_commit) begin
      for (int j = 0; j < 4; j++) begin
        if (w_c_we[j]) begin
          r_mem[w_c_idx][8*j +: 8] <= w_c_wdata[8*j +: 8];
        end
      end
    end
  end

  assign MReadData     = r_rdata;
  assign DataMem_Ready = (r_state == c_state_resp);
  assign Busy          = (r_state != c_state_idle);

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ============================================================================
// Module   : tb_data_mem_responder
// Purpose  : Directed self-checking bench; three responders at LATENCY 1, 0, 3.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_mem_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [3:0]  we    [3];
  logic        re    [3];
  logic [31:0] rdata [3];
  logic        ready [3];
  logic        busy  [3];
  logic [7:0]  m_lfsr [3];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) u_dut0 (
    .clock(clock), .reset(reset), .Address(addr[0]), .MWriteData(wdata[0]),
    .WriteEnable(we[0]), .ReadEnable(re[0]), .MReadData(rdata[0]),
    .DataMem_Ready(ready[0]), .Busy(busy[0]));

  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(0)) u_dut1 (
    .clock(clock), .reset(reset), .Address(addr[1]), .MWriteData(wdata[1]),
    .WriteEnable(we[1]), .ReadEnable(re[1]), .MReadData(rdata[1]),
    .DataMem_Ready(ready[1]), .Busy(busy[1]));

  data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(3)) u_dut2 (
    .clock(clock), .reset(reset), .Address(addr[2]), .MWriteData(wdata[2]),
    .WriteEnable(we[2]), .ReadEnable(re[2]), .MReadData(rdata[2]),
    .DataMem_Ready(ready[2]), .Busy(busy[2]));

  function automatic int lat_of(input int d);
    case (d)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // mode 0: drop request in the Ready cycle; 1: hold it one more cycle;
  // 2: return in the Ready cycle with the request still driven
  task automatic do_access(input int d, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] wen, input logic ren, input int mode,
                           input string tag, output logic [31:0] rd, output int n);
    int exp_n;
    addr[d] = a; wdata[d] = wd; we[d] = wen; re[d] = ren;
    @(posedge clock);
    exp_n = 1 + lat_of(d);
`ifdef DMEM_RAND_WAIT_EN
    exp_n += int'(m_lfsr[d][1:0]);
    m_lfsr[d] = lfsr_next(m_lfsr[d]);
`endif
    #1;
    n = 1;
    while (ready[d] !== 1'b1 && n < 64) begin
      @(posedge clock); #1;
      n++;
    end
    check({tag, "_delay"}, n, exp_n);
    rd = rdata[d];
    if (mode == 2) return;
    if (mode == 0) begin we[d] = 4'd0; re[d] = 1'b0; end
    @(posedge clock); #1;
    if (mode == 1) begin we[d] = 4'd0; re[d] = 1'b0; end
    check({tag, "_ready_after"}, ready[d], 1'b0);
    check({tag, "_busy_after"}, busy[d], 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          n;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      addr[i] = 32'h0; wdata[i] = 32'h0; we[i] = 4'd0; re[i] = 1'b0;
      m_lfsr[i] = 8'hA5;
    end
    #12;
    for (int i = 0; i < 3; i++) begin
      check("reset_ready", ready[i], 1'b0);
      check("reset_rdata", rdata[i], 32'h0);
      check("reset_busy",  busy[i],  1'b0);
    end
    @(negedge clock);
    reset = 1'b0;

    // LATENCY=1 write/read, plus address aliasing
    do_access(0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 0, "t1_wr", rd, n);
    check("t1_rdata_after_write", rdata[0], 32'h0);
    do_access(0, 32'h10, 32'h0, 4'h0, 1'b1, 0, "t1_rd", rd, n);
    check("t1_rdata", rd, 32'hDEADBEEF);
    do_access(0, 32'h1013, 32'h0, 4'h0, 1'b1, 0, "t1_alias", rd, n);
    check("t1_alias_rdata", rd, 32'hDEADBEEF);

    // Byte-lane write
    do_access(0, 32'h20, 32'h11223344, 4'hF, 1'b0, 0, "t2_pre", rd, n);
    do_access(0, 32'h20, 32'hAAAAAAAA, 4'b0100, 1'b0, 0, "t2_wr", rd, n);
    check("t2_rdata_hold", rdata[0], 32'hDEADBEEF);
    do_access(0, 32'h20, 32'h0, 4'h0, 1'b1, 0, "t2_rd", rd, n);
    check("t2_rdata", rd, 32'h11AA3344);

    // Request held through Ready: a second service would return the new word
    do_access(0, 32'h40, 32'h12345678, 4'hF, 1'b0, 0, "t3_pre", rd, n);
    do_access(0, 32'h40, 32'hCAFEF00D, 4'hF, 1'b1, 1, "t3_rw", rd, n);
    check("t3_rbw_rdata", rd, 32'h12345678);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      check("t3_no_second_ready", ready[0], 1'b0);
    end
    check("t3_rdata_hold", rdata[0], 32'h12345678);
    do_access(0, 32'h40, 32'h0, 4'h0, 1'b1, 0, "t3_rd", rd, n);
    check("t3_rdata_new", rd, 32'hCAFEF00D);

    // LATENCY=0 back-to-back reads
    do_access(1, 32'h0, 32'hA0A0A0A0, 4'hF, 1'b0, 0, "t4_pre0", rd, n);
    do_access(1, 32'h4, 32'hB1B1B1B1, 4'hF, 1'b0, 0, "t4_pre4", rd, n);
    do_access(1, 32'h0, 32'h0, 4'h0, 1'b1, 2, "t4_rd0", rd, n);
    check("t4_rdata0", rd, 32'hA0A0A0A0);
    addr[1] = 32'h4;
    @(posedge clock); #1;
    check("t4_gap_busy", busy[1], 1'b0);
    check("t4_gap_ready", ready[1], 1'b0);
    do_access(1, 32'h4, 32'h0, 4'h0, 1'b1, 0, "t4_rd4", rd, n);
    check("t4_rdata4", rd, 32'hB1B1B1B1);

    // Reset during WAIT aborts the write
    do_access(2, 32'h30, 32'h0BADF00D, 4'hF, 1'b0, 0, "t5_pre", rd, n);
    @(negedge clock);
    addr[2] = 32'h30; wdata[2] = 32'hFFFFFFFF; we[2] = 4'hF;
    @(posedge clock); #1;
    check("t5_busy_wait", busy[2], 1'b1);
    @(posedge clock); #1;
    check("t5_ready_wait", ready[2], 1'b0);
    reset = 1'b1;
    we[2] = 4'h0;
    #1;
    check("t5_busy_reset", busy[2], 1'b0);
    check("t5_rdata_reset", rdata[2], 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clock); #1;
      check("t5_ready_reset", ready[2], 1'b0);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) m_lfsr[i] = 8'hA5;
    do_access(2, 32'h30, 32'h0, 4'h0, 1'b1, 0, "t5_rd", rd, n);
    check("t5_rdata_old", rd, 32'h0BADF00D);

`ifdef DMEM_RAND_WAIT_EN
    // Randomised waits: exact delay checked against the reference LFSR
    for (int i = 0; i < 64; i++) begin
      do_access(0, 32'h10, 32'h0, 4'h0, 1'b1, 0, "t6", rd, n);
      check("t6_range", (n >= 2 && n <= 5), 1'b1);
      check("t6_rdata", rd, 32'hDEADBEEF);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
